// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_mp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

endpackage

// File: rtl/regfile_mp_bank.sv
// One storage bank: single write port, one registered read port, r0 reads as zero.
// Same-cycle write-to-read forwarding is selected by REGFILE_MP_BYPASS_EN.
module regfile_mp_bank
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic [AW-1:0]   i_rd_addr,
  output logic [XLEN-1:0] o_rd_data
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic [XLEN-1:0] r_rd_data;
  logic [XLEN-1:0] w_rd_next;

  // Storage is never reset asynchronously; the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (i_we && (i_wr_addr != '0)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    w_rd_next = r_mem[i_rd_addr];
`ifdef REGFILE_MP_BYPASS_EN
    if (i_we && (i_wr_addr == i_rd_addr)) begin
      w_rd_next = i_wr_data;
    end
`endif
    if (i_clear || (i_rd_addr == '0)) begin
      w_rd_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: NRD replicated banks plus a post-reset clear FSM.
// Optional write-first forwarding via macro REGFILE_MP_BYPASS_EN (default read-first).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic              init_busy,
  output state_e            o_dbg_state
);

  state_e          r_state;
  state_e          w_state_next;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_next;
  logic            w_clear;
  logic            w_bank_we;
  logic [AW-1:0]   w_bank_addr;
  logic [XLEN-1:0] w_bank_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The counter stops once RUN is reached, so there is never a second pass.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      CLEAR: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == AW'(NREGS - 1)) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_state_next = RUN;
      end
      default: begin
        w_state_next = CLEAR;
      end
    endcase
  end

  assign w_clear     = (r_state == CLEAR);
  assign init_busy   = w_clear;
  assign o_dbg_state = r_state;

  // During CLEAR the write port belongs to the counter and user writes are dropped.
  assign w_bank_we   = w_clear | (we & (wr_addr != '0));
  assign w_bank_addr = w_clear ? r_cnt : wr_addr;
  assign w_bank_data = w_clear ? '0 : wr_data;

  for (genvar p = 0; p < NRD; p++) begin : g_bank
    regfile_mp_bank #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_clear),
      .i_we      (w_bank_we),
      .i_wr_addr (w_bank_addr),
      .i_wr_data (w_bank_data),
      .i_rd_addr (rd_addr[p*AW +: AW]),
      .o_rd_data (rd_data[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: random and directed traffic against an array model.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
  localparam int W     = NRD*XLEN + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              we = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [XLEN-1:0]   wr_data = '0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic              init_busy;
  state_e            dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    mon_e;
  logic [XLEN-1:0] mm [NREGS];
  int              clear_left = 0;
  int              drain_cnt;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .init_busy   (init_busy),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts {init_busy, rd_data} after the next edge.
  task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    logic [W-1:0]    e;
    logic [AW-1:0]   ra [NRD];
    logic [XLEN-1:0] v;
    logic            in_clear;
    @(negedge clk);
    we      = w;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = {ra1, ra0};
    ra[0] = ra0;
    ra[1] = ra1;
    in_clear = (clear_left > 0);
    for (int p = 0; p < NRD; p++) begin
      v = mm[ra[p]];
`ifdef REGFILE_MP_BYPASS_EN
      if (!in_clear && w && wa != 0 && wa == ra[p]) v = wd;
`endif
      if (in_clear || ra[p] == 0) v = '0;
      e[p*XLEN +: XLEN] = v;
    end
    e[W-1] = (clear_left > 1);
    exp_q.push_back(e);
    if (in_clear) clear_left--;
    else if (w && wa != 0) mm[wa] = wd;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREGS-1));
  endfunction

  task automatic rand_cycle();
    cycle(1'($urandom_range(0, 1)), rnd_addr(), $urandom, rnd_addr(), rnd_addr());
  endtask

  // Released just after a rising edge so the next cycle() lines up with clear edge 1.
  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_left = NREGS;
    for (int i = 0; i < NREGS; i++) mm[i] = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    we = 1'b1;
    wr_addr = AW'(9);
    wr_data = $urandom;
    #1;
    check("async_reset", {init_busy, rd_data}, {1'b1, {(NRD*XLEN){1'b0}}});
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {init_busy, rd_data}, {1'b1, {(NRD*XLEN){1'b0}}});
    release_reset();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rd_port", {init_busy, rd_data}, mon_e);
      end
    end
  end

  initial begin
    for (int i = 0; i < NREGS; i++) mm[i] = '0;
    we = 1'b1;
    wr_addr = AW'(4);
    wr_data = 32'h5A5A5A5A;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {init_busy, rd_data}, {1'b1, {(NRD*XLEN){1'b0}}});
    release_reset();

    // Clear sequence: a write attempt to r3 must be dropped.
    cycle(1'b1, AW'(3), 32'hAAAA5555, AW'(3), AW'(3));
    repeat (NREGS-1) rand_cycle();
    for (int i = 0; i < NREGS; i++) cycle(1'b0, '0, '0, AW'(i), AW'(NREGS-1-i));
    cycle(1'b0, '0, '0, AW'(3), AW'(3));

    cycle(1'b1, AW'(5), 32'hDEADBEEF, AW'(1), AW'(2));
    cycle(1'b0, '0, '0, AW'(5), AW'(5));
    cycle(1'b1, AW'(0), 32'h12345678, AW'(0), AW'(0));
    cycle(1'b0, '0, '0, AW'(0), AW'(0));
    cycle(1'b1, AW'(7), 32'h11111111, AW'(5), AW'(0));
    cycle(1'b1, AW'(7), 32'h22222222, AW'(7), AW'(7));
    cycle(1'b0, '0, '0, AW'(7), AW'(7));
    cycle(1'b1, AW'(31), 32'hFFFFFFFF, AW'(31), AW'(30));
    cycle(1'b0, '0, '0, AW'(31), AW'(30));

    repeat (400) rand_cycle();

    cycle(1'b1, AW'(9), 32'hCAFEF00D, AW'(2), AW'(3));
    cycle(1'b0, '0, '0, AW'(9), AW'(9));
    pulse_reset();
    repeat (NREGS) rand_cycle();
    cycle(1'b0, '0, '0, AW'(9), AW'(9));
    repeat (100) rand_cycle();

    drain_cnt = 0;
    while (exp_q.size() != 0 && drain_cnt < 10) begin
      @(posedge clk);
      drain_cnt++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
